// File: rtl/mips_cpu_hilo_div_ctrl.sv
// HI/LO register file and multi-cycle divider sequencer for a MIPS pipeline.
// Issues, restarts and times out divides; serves MTHI/MTLO/MFHI/MFLO in IDLE.
`timescale 1ns/1ps
module mips_cpu_hilo_div_ctrl #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        op_ready,
  output logic [31:0] rd_val,
  output logic        rd_valid,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbz_flag,
  output logic        timeout_err,
  output logic        div_start,
  output logic        div_sign,
  output logic        div_reset,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done,
  input  logic        div_dbz
);

  typedef enum logic [1:0] {IDLE, ABORT, START, WAIT} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_DIV  = 3'b000;
  localparam logic [2:0] OP_DIVU = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;
  localparam logic [2:0] OP_MFHI = 3'b100;
  localparam logic [2:0] OP_MFLO = 3'b101;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, rd_val_q, rd_val_d;
  logic [31:0]   dividend_q, dividend_d, divisor_q, divisor_d;
  logic          rd_valid_q, rd_valid_d, start_q, start_d, sign_q, sign_d;
  logic          dbz_q, dbz_d, tmo_q, tmo_d, rst_pulse_q, rst_pulse_d;
  logic          is_div_s, accept_s;

  // Handshake: divides are always accepted (they restart), everything else stalls unless IDLE.
  always_comb begin
    is_div_s = (op == OP_DIV) || (op == OP_DIVU);
    op_ready = is_div_s || (state_q == IDLE);
    accept_s = op_valid && op_ready;
  end

  // Next-state and datapath update; a newly accepted divide overrides whatever WAIT would do.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    rd_val_d    = rd_val_q;
    rd_valid_d  = 1'b0;
    start_d     = 1'b0;
    rst_pulse_d = 1'b0;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    sign_d      = sign_q;
    dbz_d       = dbz_q;
    tmo_d       = tmo_q;
    if (accept_s && is_div_s) begin
      dividend_d = rs_val;
      divisor_d  = rt_val;
      sign_d     = (op == OP_DIV);
      dbz_d      = 1'b0;
      tmo_d      = 1'b0;
      if (state_q == IDLE) begin
        state_d = START;
        start_d = 1'b1;
      end else begin
        state_d     = ABORT;
        rst_pulse_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            case (op)
              OP_MTHI: hi_d = rs_val;
              OP_MTLO: lo_d = rs_val;
              OP_MFHI: begin
                rd_val_d   = hi_q;
                rd_valid_d = 1'b1;
              end
              OP_MFLO: begin
                rd_val_d   = lo_q;
                rd_valid_d = 1'b1;
              end
              default: rd_valid_d = 1'b0;
            endcase
          end else begin
            state_d = IDLE;
          end
        end
        ABORT: begin
          state_d = START;
          start_d = 1'b1;
        end
        START: begin
          state_d = WAIT;
          cnt_d   = {CW{1'b0}};
        end
        WAIT: begin
          if (div_done) begin
            state_d = IDLE;
            if (div_dbz) begin
              dbz_d = 1'b1;
            end else begin
              lo_d  = div_quotient;
              hi_d  = div_remainder;
              dbz_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(TIMEOUT)) begin
              state_d     = IDLE;
              tmo_d       = 1'b1;
              rst_pulse_d = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      rd_val_q    <= 32'd0;
      rd_valid_q  <= 1'b0;
      start_q     <= 1'b0;
      rst_pulse_q <= 1'b0;
      dividend_q  <= 32'd0;
      divisor_q   <= 32'd0;
      sign_q      <= 1'b0;
      dbz_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      rd_val_q    <= rd_val_d;
      rd_valid_q  <= rd_valid_d;
      start_q     <= start_d;
      rst_pulse_q <= rst_pulse_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      sign_q      <= sign_d;
      dbz_q       <= dbz_d;
      tmo_q       <= tmo_d;
    end
  end

  // The divider is also held in reset for as long as the controller is.
  assign div_reset    = reset | rst_pulse_q;
  assign busy         = (state_q != IDLE);
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign rd_val       = rd_val_q;
  assign rd_valid     = rd_valid_q;
  assign div_start    = start_q;
  assign div_sign     = sign_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign dbz_flag     = dbz_q;
  assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_mips_cpu_hilo_div_ctrl.sv
// Directed + randomized bench for mips_cpu_hilo_div_ctrl with a behavioural divider
// and an architectural HI/LO reference model.
`timescale 1ns/1ps
module tb_mips_cpu_hilo_div_ctrl;

  logic        clk = 1'b0;
  logic        reset, op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        op_ready, rd_valid, busy, dbz_flag, timeout_err;
  logic [31:0] rd_val, hi, lo, div_dividend, div_divisor;
  logic        div_start, div_sign, div_reset;
  logic [31:0] div_quotient = 32'd0, div_remainder = 32'd0;
  logic        div_done = 1'b0, div_dbz = 1'b0;

  int n_checks = 0, n_fail = 0;
  int lat_cfg = 0;
  bit never_done = 1'b0;
  bit pending = 1'b0;
  int remain = 0;
  int start_cnt = 0, dreset_cnt = 0;
  logic [31:0] mh = 32'd0, ml = 32'd0;
  logic        mdbz = 1'b0, mto = 1'b0;

  mips_cpu_hilo_div_ctrl #(.TIMEOUT(63)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .op_ready(op_ready), .rd_val(rd_val), .rd_valid(rd_valid), .busy(busy), .hi(hi), .lo(lo),
    .dbz_flag(dbz_flag), .timeout_err(timeout_err), .div_start(div_start), .div_sign(div_sign),
    .div_reset(div_reset), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done), .div_dbz(div_dbz)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hDEAD_BEEF;
      r = 32'hBAD0_BAD0;
    end else if (sgn) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Behavioural divider: result lat_cfg cycles after the first WAIT cycle, cancelled by div_reset.
  always @(negedge clk) begin
    if (div_reset) begin
      pending = 1'b0;
      div_done = 1'b0;
    end else if (div_start) begin
      pending = !never_done;
      remain = lat_cfg;
      div_done = 1'b0;
      div_dbz = (div_divisor == 32'd0);
      ref_div(div_sign, div_dividend, div_divisor, div_quotient, div_remainder);
    end else if (pending && remain == 0) begin
      div_done = 1'b1;
      pending = 1'b0;
    end else begin
      if (pending) remain--;
      div_done = 1'b0;
    end
  end

  // Pulse counters for div_start / div_reset outside of reset.
  always @(posedge clk) begin
    if (!reset) begin
      if (div_start) start_cnt++;
      if (div_reset) dreset_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    #1;
    while (!op_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_bound", 32'(op_ready), 32'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0; op = 3'b111;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_bound", 32'(busy), 32'd0);
  endtask

  task automatic apply_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    mto = 1'b0;
    if (b == 32'd0) begin
      mdbz = 1'b1;
    end else begin
      ref_div(sgn, a, b, q, r);
      ml = q; mh = r; mdbz = 1'b0;
    end
  endtask

  task automatic check_arch(input string tag);
    check({tag, "_hi"}, hi, mh);
    check({tag, "_lo"}, lo, ml);
    check({tag, "_dbz"}, 32'(dbz_flag), 32'(mdbz));
    check({tag, "_tmo"}, 32'(timeout_err), 32'(mto));
  endtask

  initial begin
    int s_start, s_rst, n;
    logic [31:0] prev_hi, prev_lo;
    reset = 1'b1; op_valid = 1'b0; op = 3'b111; rs_val = 32'd0; rt_val = 32'd0;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_rd_val", rd_val, 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_div_sign", 32'(div_sign), 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_divisor", div_divisor, 32'd0);
    check("rst_div_reset", 32'(div_reset), 32'd1);
    check_arch("rst");
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(op_ready), 32'd1);
    check("post_rst_div_reset", 32'(div_reset), 32'd0);

    // DIVU 100/7
    lat_cfg = 2; s_start = start_cnt;
    issue(3'b001, 32'd100, 32'd7);
    check("divu_start", 32'(div_start), 32'd1);
    check("divu_sign", 32'(div_sign), 32'd0);
    check("divu_busy", 32'(busy), 32'd1);
    check("divu_dividend", div_dividend, 32'd100);
    check("divu_divisor", div_divisor, 32'd7);
    wait_idle();
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    check("divu_nstart", 32'(start_cnt - s_start), 32'd1);
    apply_div(1'b0, 32'd100, 32'd7);

    // DIV -7/2
    issue(3'b000, 32'hFFFF_FFF9, 32'd2);
    check("div_sign", 32'(div_sign), 32'd1);
    wait_idle();
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    apply_div(1'b1, 32'hFFFF_FFF9, 32'd2);

    // Minimum latency: accept N, done at N+2, visible in N+3
    lat_cfg = 0;
    issue(3'b001, 32'd77, 32'd5);
    @(posedge clk); #1;
    check("minlat_busy_n2", 32'(busy), 32'd1);
    check("minlat_lo_n2", lo, ml);
    @(posedge clk); #1;
    check("minlat_busy_n3", 32'(busy), 32'd0);
    check("minlat_lo_n3", lo, 32'd15);
    check("minlat_hi_n3", hi, 32'd2);
    apply_div(1'b0, 32'd77, 32'd5);

    // MFLO stalled behind a divide
    lat_cfg = 4;
    issue(3'b001, 32'd1000, 32'd9);
    op_valid = 1'b1; op = 3'b101;
    #1;
    check("mflo_stall", 32'(op_ready), 32'd0);
    issue(3'b101, 32'd0, 32'd0);
    apply_div(1'b0, 32'd1000, 32'd9);
    check("mflo_rd_valid", 32'(rd_valid), 32'd1);
    check("mflo_rd_val", rd_val, 32'd111);
    @(posedge clk); #1;
    check("mflo_rd_valid_drop", 32'(rd_valid), 32'd0);
    check("mflo_rd_val_hold", rd_val, 32'd111);

    // MTHI/MTLO/MFHI, then divide by zero
    issue(3'b010, 32'h11, 32'd0); mh = 32'h11;
    issue(3'b011, 32'h22, 32'd0); ml = 32'h22;
    issue(3'b100, 32'd0, 32'd0);
    check("mfhi_rd_val", rd_val, 32'h11);
    lat_cfg = 1;
    issue(3'b001, 32'd5, 32'd0);
    wait_idle();
    apply_div(1'b0, 32'd5, 32'd0);
    check_arch("dbz");
    check("dbz_flag_set", 32'(dbz_flag), 32'd1);
    issue(3'b001, 32'd9, 32'd4);
    check("dbz_clear_on_accept", 32'(dbz_flag), 32'd0);
    wait_idle();
    apply_div(1'b0, 32'd9, 32'd4);
    check_arch("after_dbz");

    // Restart: DIVU 10/3 then DIVU 9/3 three cycles later
    lat_cfg = 20; s_start = start_cnt; s_rst = dreset_cnt;
    issue(3'b001, 32'd10, 32'd3);
    @(posedge clk); @(posedge clk);
    lat_cfg = 3;
    issue(3'b001, 32'd9, 32'd3);
    check("restart_abort_rst", 32'(div_reset), 32'd1);
    check("restart_dividend", div_dividend, 32'd9);
    wait_idle();
    check("restart_lo", lo, 32'd3);
    check("restart_hi", hi, 32'd0);
    check("restart_nrst", 32'(dreset_cnt - s_rst), 32'd1);
    check("restart_nstart", 32'(start_cnt - s_start), 32'd2);
    apply_div(1'b0, 32'd9, 32'd3);

    // Restart in the same cycle WAIT sees div_done
    lat_cfg = 0;
    issue(3'b001, 32'd50, 32'd7);
    @(posedge clk);
    lat_cfg = 2; prev_hi = hi; prev_lo = lo;
    issue(3'b001, 32'd64, 32'd8);
    check("race_lo_kept", lo, prev_lo);
    check("race_hi_kept", hi, prev_hi);
    check("race_abort", 32'(div_reset), 32'd1);
    wait_idle();
    apply_div(1'b0, 32'd64, 32'd8);
    check_arch("race");

    // Timeout
    never_done = 1'b1; s_rst = dreset_cnt;
    issue(3'b001, 32'd20, 32'd3);
    n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("tmo_busy_cycles", 32'(n), 32'd64);
    check("tmo_div_reset", 32'(div_reset), 32'd1);
    mto = 1'b1; mdbz = 1'b0;
    check_arch("tmo");
    @(posedge clk); #1;
    check("tmo_div_reset_drop", 32'(div_reset), 32'd0);
    check("tmo_nrst", 32'(dreset_cnt - s_rst), 32'd1);
    never_done = 1'b0; lat_cfg = 1;
    issue(3'b001, 32'd30, 32'd4);
    check("tmo_clear_on_accept", 32'(timeout_err), 32'd0);
    wait_idle();
    apply_div(1'b0, 32'd30, 32'd4);
    check_arch("after_tmo");

    // Randomized operation mix
    for (int i = 0; i < 60; i++) begin
      logic [2:0] o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 6) == 0) b = 32'd0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else b = 32'($urandom_range(1, 50));
      lat_cfg = $urandom_range(0, 5);
      issue(o, a, b);
      check("rnd_rd_valid", 32'(rd_valid), 32'((o == 3'b100) || (o == 3'b101)));
      case (o)
        3'b000, 3'b001: begin
          if ($urandom_range(0, 2) == 0) begin
            a = $urandom; b = 32'($urandom_range(1, 1000));
            issue(o, a, b);
          end
          wait_idle();
          apply_div(o == 3'b000, a, b);
        end
        3'b010: mh = a;
        3'b011: ml = a;
        3'b100: check("rnd_mfhi", rd_val, mh);
        3'b101: check("rnd_mflo", rd_val, ml);
        default: n = 0;
      endcase
      check_arch("rnd");
    end

    // Reset in the middle of a divide
    lat_cfg = 10;
    issue(3'b001, 32'd7, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_div_reset", 32'(div_reset), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_ready", 32'(op_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    mh = 32'd0; ml = 32'd0; mdbz = 1'b0; mto = 1'b0;
    repeat (15) @(negedge clk);
    check_arch("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_hilo_div_ctrl.md
MIPS_CPU_HILO_DIV_CTRL -- requirements
Module: mips_cpu_hilo_div_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 63, maximum cycles spent in WAIT before the operation is abandoned.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op_valid  in  1  CPU presents an operation this cycle.
REQ-005 op  in  3  000 DIV, 001 DIVU, 010 MTHI, 011 MTLO, 100 MFHI, 101 MFLO; 110/111 accepted and ignored.
REQ-006 rs_val  in  32  dividend for DIV/DIVU; source for MTHI/MTLO.
REQ-007 rt_val  in  32  divisor for DIV/DIVU.
REQ-008 op_ready  out  1  operation accepted when op_valid && op_ready.
REQ-009 rd_val  out  32  MFHI/MFLO result; rd_valid  out  1  one-cycle qualifier.
REQ-010 busy  out  1  high whenever state != IDLE.
REQ-011 hi, lo  out  32 each  architectural HI/LO registers.
REQ-012 dbz_flag  out  1  last completed divide had a zero divisor; timeout_err  out  1  last divide timed out.
REQ-013 div_start, div_sign, div_reset  out  1 each; div_dividend, div_divisor  out  32 each: divider drive.
REQ-014 div_quotient, div_remainder  in  32 each; div_done, div_dbz  in  1 each: divider results.

Function
REQ-015 States: IDLE, ABORT, START, WAIT; busy = (state != IDLE).
REQ-016 op_ready: 1 for DIV/DIVU in any state; 1 for all other ops only in IDLE; 0 otherwise (stall).
REQ-017 DIV/DIVU accepted in IDLE: latch rs_val/rt_val into div_dividend/div_divisor, div_sign = (op==DIV); next state START.
REQ-018 DIV/DIVU accepted in START/WAIT/ABORT: latch new operands; next state ABORT (restart).
REQ-019 ABORT: div_reset = 1 for exactly that cycle; next state START.
REQ-020 START: div_start = 1 for exactly that cycle; WAIT counter cleared; next state WAIT.
REQ-021 div_dividend, div_divisor, div_sign stay constant from acceptance until return to IDLE or a restart.
REQ-022 WAIT, div_done = 1, div_dbz = 0: lo <= div_quotient, hi <= div_remainder, dbz_flag <= 0; next state IDLE.
REQ-023 WAIT, div_done = 1, div_dbz = 1: hi/lo unchanged, dbz_flag <= 1; next state IDLE.
REQ-024 WAIT, div_done = 0: counter increments; when counter reaches TIMEOUT, timeout_err <= 1, div_reset pulsed one cycle, hi/lo unchanged, next state IDLE.
REQ-025 Acceptance of DIV/DIVU clears dbz_flag and timeout_err on the same edge.
REQ-026 div_done is sampled only in WAIT; div_done in any other state is ignored.
REQ-027 DIV/DIVU accepted in the same cycle that WAIT sees div_done: the restart wins; hi/lo not written.
REQ-028 MTHI/MTLO accepted in IDLE: hi/lo <= rs_val on that edge.
REQ-029 MFHI/MFLO accepted at cycle N: rd_valid = 1 and rd_val = hi/lo value at the end of cycle N, both in cycle N+1.
REQ-030 rd_valid otherwise 0; rd_val holds its last value.
REQ-031 Minimum divide latency: accept at N, div_start at N+1, earliest hi/lo update at the edge ending N+2 given div_done at N+2.
REQ-032 Sign handling is the divider's responsibility; the controller only drives div_sign.

Reset
REQ-033 reset = 1: state IDLE; hi, lo, rd_val, div_dividend, div_divisor = 0; rd_valid, div_start, div_sign, dbz_flag, timeout_err = 0.
REQ-034 div_reset = 1 while reset = 1 (combinational OR with the ABORT/timeout pulse).
REQ-035 Reset mid-operation abandons it; no hi/lo write; op_ready = 1 in the first cycle after reset deasserts.

Verification
REQ-036 DIVU 100/7 in IDLE -> div_start pulse next cycle, div_sign = 0; after div_done: lo = 14, hi = 2, busy = 0 the following cycle.
REQ-037 DIV 0xFFFFFFF9/2 -> div_sign = 1; after done: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-038 MFLO held valid during WAIT -> op_ready = 0 until IDLE; accepted then; rd_valid one cycle later with rd_val = new lo.
REQ-039 DIVU 5/0 with hi = 0x11, lo = 0x22 -> dbz_flag = 1, hi = 0x11, lo = 0x22.
REQ-040 DIVU 10/3, then DIVU 9/3 three cycles later -> one div_reset pulse, one new div_start; final lo = 3, hi = 0; 10/3 result never written.
REQ-041 Divider model never asserts div_done -> after 63 WAIT cycles: timeout_err = 1, div_reset pulse, state IDLE, hi/lo unchanged.
